// File: rtl/func_seq_if.sv
// rtl/func_seq_if.sv - operand/result stream bundle for func_seq
interface func_seq_if;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_res;
  logic       out_ready;

  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_res);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_res);
endinterface

// File: rtl/func_seq.sv
// rtl/func_seq.sv - queues operand pairs, sequences the func engine, queues results
// Optional watchdog compiled in with FUNC_SEQ_TIMEOUT_EN.
module func_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  func_seq_if.slave  s,
  output logic       f_start,
  output logic [7:0] f_a,
  output logic [7:0] f_b,
  input  logic [9:0] f_res,
  input  logic       f_busy,
  output logic [2:0] pending,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, STORE} state_t;
  state_t state, state_nx;

  logic [7:0] op_a_mem [DEPTH];
  logic [7:0] op_b_mem [DEPTH];
  logic [9:0] res_mem  [DEPTH];
  logic [AW:0] op_wp, op_rp, res_wp, res_rp;
  logic [AW:0] op_count;
  logic        op_empty, op_full, res_empty, res_full;
  logic        op_push, op_pop, res_push, res_pop;
  logic        cap_en, cap_to, to_hit;
  logic [9:0]  res_q;
  logic [AW+1:0] pend_sum;

  assign op_empty  = (op_wp == op_rp);
  assign op_full   = (op_wp[AW] != op_rp[AW]) && (op_wp[AW-1:0] == op_rp[AW-1:0]);
  assign res_empty = (res_wp == res_rp);
  assign res_full  = (res_wp[AW] != res_rp[AW]) && (res_wp[AW-1:0] == res_rp[AW-1:0]);
  assign op_count  = op_wp - op_rp;

  assign s.in_ready  = !op_full;
  assign s.out_valid = !res_empty;
  assign s.out_res   = res_mem[res_rp[AW-1:0]];
  assign op_push     = s.in_valid && !op_full;
  assign res_pop     = s.out_ready && !res_empty;

  // The head operand stays queued until STORE, so it counts in occupancy and as the in-flight job.
  assign pend_sum = {1'b0, op_count} + {{(AW+1){1'b0}}, (state != IDLE)};
  assign pending  = (pend_sum > (AW+2)'(7)) ? 3'd7 : pend_sum[2:0];

  always_comb begin
    state_nx = state;
    f_start  = 1'b0;
    op_pop   = 1'b0;
    res_push = 1'b0;
    cap_en   = 1'b0;
    cap_to   = 1'b0;
    case (state)
      IDLE:    if (!op_empty) state_nx = ISSUE;
      ISSUE: begin
        f_start  = 1'b1;
        state_nx = WAIT_LO;
      end
      WAIT_LO: begin
        if (!f_busy) begin
          state_nx = WAIT_HI;
        end else if (to_hit) begin
          state_nx = STORE;
          cap_to   = 1'b1;
        end
      end
      WAIT_HI: begin
        if (f_busy) begin
          state_nx = STORE;
          cap_en   = 1'b1;
        end else if (to_hit) begin
          state_nx = STORE;
          cap_to   = 1'b1;
        end
      end
      STORE: begin
        if (!res_full) begin
          res_push = 1'b1;
          op_pop   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      op_wp  <= '0;
      op_rp  <= '0;
      res_wp <= '0;
      res_rp <= '0;
      f_a    <= '0;
      f_b    <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      if (op_push)  op_wp  <= op_wp + PTR_ONE;
      if (op_pop)   op_rp  <= op_rp + PTR_ONE;
      if (res_push) res_wp <= res_wp + PTR_ONE;
      if (res_pop)  res_rp <= res_rp + PTR_ONE;
      // Operands latched on the way into ISSUE and frozen until the job is stored.
      if (state == IDLE && !op_empty) begin
        f_a <= op_a_mem[op_rp[AW-1:0]];
        f_b <= op_b_mem[op_rp[AW-1:0]];
      end
      if (cap_en)      res_q <= f_res;
      else if (cap_to) res_q <= 10'h3FF;
    end
  end

  always_ff @(posedge clk) begin
    if (op_push) begin
      op_a_mem[op_wp[AW-1:0]] <= s.in_a;
      op_b_mem[op_wp[AW-1:0]] <= s.in_b;
    end
    if (res_push) res_mem[res_wp[AW-1:0]] <= res_q;
  end

`ifdef FUNC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE)                             wd_cnt <= '0;
      else if (state == WAIT_LO || state == WAIT_HI)  wd_cnt <= wd_cnt + CW'(1);
      if (cap_to) err_q <= 1'b1;
    end
  end

  assign to_hit = (wd_cnt == CW'(TIMEOUT - 1));
  assign err    = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif
endmodule
